// File: rtl/dns_matmul.sv
// ============================================================================
// Module   : dns_matmul
// Brief    : DNS-style N x N matrix multiplier. All N^3 products form in one
//            cycle, then a pipelined adder tree reduces them over the k-plane.
//            DNS_SAT_EN: clamp narrow outputs instead of wrapping them.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dns_matmul #(
    parameter int N      = 4,
    parameter int DW     = 8,
    parameter int OW     = 2*DW + $clog2(N),
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*N*DW-1:0]    a_flat,
    input  logic [N*N*DW-1:0]    b_flat,
    output logic                 busy,
    output logic                 done,
    output logic [N*N*OW-1:0]    s_flat
);

    localparam int L   = $clog2(N);
    localparam int PW  = 2*DW;
    localparam int AW  = PW + L;
    localparam int LVW = $clog2(N+1) + 1;
    localparam bit SG  = (SIGNED != 0);
`ifdef DNS_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif
    localparam logic [OW-1:0] C_UMAX = '1;
    localparam logic [OW-1:0] C_SMAX = C_UMAX >> 1;
    localparam logic [OW-1:0] C_SMIN = ~C_SMAX;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_MUL  = 3'd2,
        S_SUM  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic                r_busy;
    logic                r_done;
    logic [N*N*OW-1:0]   r_s;
    logic [LVW-1:0]      r_lvl;
    logic [N*N*DW-1:0]   r_a;
    logic [N*N*DW-1:0]   r_b;
    logic [DW-1:0]       r_pa [N][N][N];
    logic [DW-1:0]       r_pb [N][N][N];
    logic [AW-1:0]       r_t  [N][N][N];
    logic [AW-1:0]       w_t  [N][N][N];
    logic                w_capture;

    assign busy      = r_busy;
    assign done      = r_done;
    assign s_flat    = r_s;
    assign w_capture = start && (r_state == S_IDLE || r_state == S_DONE);

    function automatic logic [OW-1:0] conv(input logic [AW-1:0] v);
        logic [OW-1:0]        res;
        logic signed [AW-1:0] hi;
        hi = '0;
        if (SG) res = OW'($signed(v));
        else    res = OW'(v);
        if (SAT && OW < AW) begin
            if (SG) begin
                // In range only if every bit above the OW-1 sign bit copies it
                hi = $signed(v) >>> (OW-1);
                if (hi != '0 && hi != '1) res = v[AW-1] ? C_SMIN : C_SMAX;
            end else if ((v >> OW) != '0) begin
                res = C_UMAX;
            end
        end
        return res;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next_state = S_LOAD;
            S_LOAD:  w_next_state = S_MUL;
            S_MUL:   w_next_state = (L == 0) ? S_DONE : S_SUM;
            S_SUM:   if (r_lvl == LVW'(L-1)) w_next_state = S_DONE;
            S_DONE:  if (start) w_next_state = S_LOAD;
            default: w_next_state = S_IDLE;
        endcase
    end

    // MUL: extended products; SUM: one in-place tree level with stride 2^lvl
    always_comb begin
        logic [PW-1:0] ea;
        logic [PW-1:0] eb;
        logic [PW-1:0] prod;
        int            stride;
        ea     = '0;
        eb     = '0;
        prod   = '0;
        stride = 1 << r_lvl;
        for (int k = 0; k < N; k++) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    if (r_state == S_MUL) begin
                        if (SG) begin
                            ea = PW'($signed(r_pa[k][r][c]));
                            eb = PW'($signed(r_pb[k][r][c]));
                        end else begin
                            ea = PW'(r_pa[k][r][c]);
                            eb = PW'(r_pb[k][r][c]);
                        end
                        prod = ea * eb;
                        if (SG) w_t[k][r][c] = AW'($signed(prod));
                        else    w_t[k][r][c] = AW'(prod);
                    end else begin
                        w_t[k][r][c] = r_t[k][r][c];
                        if ((k & (2*stride - 1)) == 0 && (k + stride) < N)
                            w_t[k][r][c] = r_t[k][r][c] + r_t[k+stride][r][c];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_s    <= '0;
            r_lvl  <= '0;
            r_a    <= '0;
            r_b    <= '0;
            for (int k = 0; k < N; k++) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        r_pa[k][r][c] <= '0;
                        r_pb[k][r][c] <= '0;
                        r_t[k][r][c]  <= '0;
                    end
                end
            end
        end else begin
            r_busy <= (w_next_state inside {S_LOAD, S_MUL, S_SUM});
            r_done <= (w_next_state == S_DONE);
            if (w_capture) begin
                r_a <= a_flat;
                r_b <= b_flat;
            end
            if (r_state == S_LOAD) begin
                for (int k = 0; k < N; k++) begin
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            r_pa[k][r][c] <= r_a[(r*N+k)*DW +: DW];
                            r_pb[k][r][c] <= r_b[(k*N+c)*DW +: DW];
                        end
                    end
                end
            end
            if (r_state == S_MUL || r_state == S_SUM) r_t <= w_t;
            if (r_state == S_MUL)      r_lvl <= '0;
            else if (r_state == S_SUM) r_lvl <= r_lvl + 1'b1;
            // Result register only moves on DONE entry, so it holds across the next run
            if (w_next_state == S_DONE && r_state != S_DONE) begin
                for (int r = 0; r < N; r++) begin
                    for (int c = 0; c < N; c++) begin
                        r_s[(r*N+c)*OW +: OW] <= conv(w_t[0][r][c]);
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire
